// File: rtl/edit_field_if.sv
// Button levels in, cursor/blink/pulse outputs back out for the edit-mode controller.
// Handshake: there is no valid/ready pair; buttons are levels sampled every clk
// edge and every output is a registered level or a one-cycle pulse.
interface edit_field_if;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] field;
  logic       edit_active;
  logic       blank;
  logic       inc;
  logic       dec;
  logic [3:0] dbg_state;

  modport slave (
    input  btn_mode, btn_up, btn_down,
    output field, edit_active, blank, inc, dec, dbg_state
  );

  modport master (
    output btn_mode, btn_up, btn_down,
    input  field, edit_active, blank, inc, dec, dbg_state
  );
endinterface

// File: rtl/edit_field_ctrl.sv
// Edit-mode cursor for the clock/date/chrono display: walks nine fields on mode
// presses, blinks the selected one, and emits inc/dec pulses for the counters.
module edit_field_ctrl #(
  parameter int BLINK_DIV   = 12500000,
  parameter int TIMEOUT_CYC = 250000000
) (
  input  logic        clk,
  input  logic        reset,
  edit_field_if.slave bus
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE = 4'd0, F1 = 4'd1, F2 = 4'd2, F3 = 4'd3, F4 = 4'd4,
    F5 = 4'd5, F6 = 4'd6, F7 = 4'd7, F8 = 4'd8, F9 = 4'd9
  } state_t;

  state_t          state, state_next;
  logic            mode_prev, up_prev, down_prev;
  logic            mode_ev, up_ev, down_ev, any_ev, ud_ev;
  logic            timeout_hit, inc_next, dec_next;
  logic [BW-1:0]   blink_cnt;
  logic            phase;
  logic [TW-1:0]   to_cnt;
  logic            edit_q, inc_q, dec_q;

  assign mode_ev = bus.btn_mode & ~mode_prev;
  assign up_ev   = bus.btn_up   & ~up_prev;
  assign down_ev = bus.btn_down & ~down_prev;
  assign ud_ev   = up_ev | down_ev;
  assign any_ev  = mode_ev | ud_ev;

  // Any button event, even one discarded by priority, keeps edit mode alive.
  assign timeout_hit = (state != IDLE) && (to_cnt == TO_LAST) && !any_ev;
  assign inc_next    = (state != IDLE) && up_ev && !down_ev && !mode_ev;
  assign dec_next    = (state != IDLE) && down_ev && !up_ev && !mode_ev;

  always_comb begin
    state_next = state;
    if (state == IDLE) begin
      if (mode_ev) state_next = F1;
    end else if (mode_ev) begin
      state_next = (state == F9) ? IDLE : state_t'(state + 4'd1);
    end else if (timeout_hit) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mode_prev <= 1'b0;
      up_prev   <= 1'b0;
      down_prev <= 1'b0;
      edit_q    <= 1'b0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
    end else begin
      state     <= state_next;
      mode_prev <= bus.btn_mode;
      up_prev   <= bus.btn_up;
      down_prev <= bus.btn_down;
      edit_q    <= (state_next != IDLE);
      inc_q     <= inc_next;
      dec_q     <= dec_next;
    end
  end

  // Restarting on adjustments keeps the field visible while it is being changed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (state_next == IDLE || state_next != state || ud_ev) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (any_ev || state == IDLE || state_next == IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign bus.field       = state;
  assign bus.dbg_state   = state;
  assign bus.edit_active = edit_q;
  assign bus.blank       = phase;
  assign bus.inc         = inc_q;
  assign bus.dec         = dec_q;

endmodule

// File: tb/tb_edit_field_ctrl.sv
// Directed bench for edit_field_ctrl: a cycle-level behavioural model feeds an
// expected queue checked every negedge, plus literal checks in the directed flow.
module tb_edit_field_ctrl;
  localparam int BLINK_DIV   = 4;
  localparam int TIMEOUT_CYC = 20;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  edit_field_if bus ();

  edit_field_ctrl #(.BLINK_DIV(BLINK_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model + scoreboard ----------------
  // Expected vector: {field[3:0], edit_active, blank, inc, dec}
  logic [7:0] exp_q[$];
  int m_field, m_quiet, m_vis;
  bit m_inc, m_dec, pm, pu, pd;

  function automatic logic [7:0] m_vec();
    bit b;
    b = (m_field != 0) && (((m_vis / BLINK_DIV) % 2) == 1);
    return {4'(m_field), (m_field != 0), b, m_inc, m_dec};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_field = 0; m_quiet = 0; m_vis = 0; m_inc = 0; m_dec = 0;
      pm = 0; pu = 0; pd = 0;
      exp_q.delete();
      exp_q.push_back(m_vec());
    end else begin
      bit em, eu, ed;
      em = bus.btn_mode && !pm;
      eu = bus.btn_up && !pu;
      ed = bus.btn_down && !pd;
      pm = bus.btn_mode; pu = bus.btn_up; pd = bus.btn_down;
      m_inc = 0; m_dec = 0;
      if (em) begin
        m_field = (m_field + 1) % 10;
        m_quiet = 0;
        m_vis   = 0;
      end else if (m_field != 0) begin
        if (eu || ed) begin
          m_quiet = 0;
          m_vis   = 0;
          m_inc   = eu && !ed;
          m_dec   = ed && !eu;
        end else begin
          m_quiet++;
          m_vis++;
          if (m_quiet >= TIMEOUT_CYC) begin
            m_field = 0;
            m_vis   = 0;
          end
        end
      end
      exp_q.delete();
      exp_q.push_back(m_vec());
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      chk("sb_field", int'(bus.field), int'(e[7:4]));
      chk("sb_edit_active", int'(bus.edit_active), int'(e[3]));
      chk("sb_blank", int'(bus.blank), int'(e[2]));
      chk("sb_inc", int'(bus.inc), int'(e[1]));
      chk("sb_dec", int'(bus.dec), int'(e[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic press_mode(input int n);
    repeat (n) begin
      bus.btn_mode = 1'b1; step();
      bus.btn_mode = 1'b0; step();
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [11:0] pat;
    checks = 0; errors = 0;
    reset = 1'b0;
    bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    repeat (3) step();
    chk("reset_field", int'(bus.field), 0);
    chk("reset_blank", int'(bus.blank), 0);
    reset = 1'b1;
    repeat (30) step();
    chk("idle_field", int'(bus.field), 0);
    chk("idle_edit_active", int'(bus.edit_active), 0);

    // up in IDLE is ignored
    bus.btn_up = 1'b1; step();
    chk("idle_up_inc", int'(bus.inc), 0);
    bus.btn_up = 1'b0; step();

    // cursor walk 1..9,0
    for (int i = 1; i <= 10; i++) begin
      bus.btn_mode = 1'b1; step();
      chk("walk_field", int'(bus.field), i % 10);
      chk("walk_edit_active", int'(bus.edit_active), (i % 10) != 0 ? 1 : 0);
      bus.btn_mode = 1'b0; step();
    end

    // held mode gives one step
    bus.btn_mode = 1'b1; step();
    chk("hold_first", int'(bus.field), 1);
    repeat (9) step();
    chk("hold_still", int'(bus.field), 1);
    bus.btn_mode = 1'b0; step();

    // inc/dec in field 4
    press_mode(3);
    chk("at_field4", int'(bus.field), 4);
    bus.btn_up = 1'b1; step();
    chk("up_inc", int'(bus.inc), 1);
    chk("up_field", int'(bus.field), 4);
    step();
    chk("up_inc_once", int'(bus.inc), 0);
    bus.btn_up = 1'b0; step();
    bus.btn_down = 1'b1; step();
    chk("down_dec", int'(bus.dec), 1);
    step();
    chk("down_dec_once", int'(bus.dec), 0);
    bus.btn_down = 1'b0; step();
    bus.btn_up = 1'b1; bus.btn_down = 1'b1; step();
    chk("both_inc", int'(bus.inc), 0);
    chk("both_dec", int'(bus.dec), 0);
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; step();

    // mode beats up in field 2
    press_mode(8);
    chk("at_field2", int'(bus.field), 2);
    bus.btn_mode = 1'b1; bus.btn_up = 1'b1; step();
    chk("prio_field", int'(bus.field), 3);
    chk("prio_inc", int'(bus.inc), 0);
    bus.btn_mode = 1'b0; bus.btn_up = 1'b0; step();

    // blink pattern on entering field 1
    press_mode(7);
    chk("back_idle", int'(bus.field), 0);
    pat = 12'b0000_1111_0000;
    bus.btn_mode = 1'b1; step();
    bus.btn_mode = 1'b0;
    for (int j = 0; j < 12; j++) begin
      chk("blink_pat", int'(bus.blank), int'(pat[11-j]));
      step();
    end
    chk("blink_off_before_up", int'(bus.blank), 1);
    bus.btn_up = 1'b1; step();
    bus.btn_up = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk("blink_restart", int'(bus.blank), j < 4 ? 0 : 1);
      step();
    end

    // timeout from field 5
    press_mode(4);
    repeat (18) step();
    chk("to_field_19", int'(bus.field), 5);
    step();
    chk("to_field_20", int'(bus.field), 0);

    // event on the last quiet cycle wins over timeout
    press_mode(5);
    repeat (18) step();
    bus.btn_up = 1'b1; step();
    chk("to_saved_field", int'(bus.field), 5);
    chk("to_saved_inc", int'(bus.inc), 1);
    bus.btn_up = 1'b0; step();
    chk("to_saved_after", int'(bus.field), 5);

    // async reset mid-pulse
    bus.btn_up = 1'b1; step();
    chk("pre_reset_inc", int'(bus.inc), 1);
    #1 reset = 1'b0;
    #1;
    chk("async_inc", int'(bus.inc), 0);
    chk("async_field", int'(bus.field), 0);
    chk("async_edit_active", int'(bus.edit_active), 0);
    bus.btn_up = 1'b0;
    step(); step();
    reset = 1'b1;
    repeat (3) step();
    chk("post_reset_field", int'(bus.field), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
